shift_code_checker: RTL



---
 rtl/shift_code_pkg.sv | 37 +++
 rtl/shift_code_checker_classify.sv | 38 +++
 rtl/shift_code_checker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/shift_code_pkg.sv
// rtl/shift_code_pkg.sv - shared mode constants, checker state type and code successor functions
// Contents:
//   MODE_JOHNSON / MODE_RING : values for the RING parameter
//   chk_state_t              : checker lock state machine encoding
//   johnson_succ / ring_succ : next code word for an n-bit twisted / plain ring counter
package shift_code_pkg;

    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;

    // Widest code word the helper functions handle; callers zero-extend into
    // this width and truncate the result back to their own N.
    localparam int MAX_N = 32;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Twisted-ring step: shift right, inverted LSB enters at bit n-1.
    function automatic logic [MAX_N-1:0] johnson_succ(input logic [MAX_N-1:0] c, input int n);
        logic [MAX_N-1:0] r;
        r        = c >> 1;
        r[n-1]   = ~c[0];
        return r;
    endfunction

    // Plain ring step: rotate right within the low n bits.
    function automatic logic [MAX_N-1:0] ring_succ(input logic [MAX_N-1:0] c, input int n);
        logic [MAX_N-1:0] r;
        r        = c >> 1;
        r[n-1]   = c[0];
        return r;
    endfunction

endpackage

// File: rtl/shift_code_checker_classify.sv
// rtl/shift_code_checker_classify.sv - combinational legality check and position decode of one code word
// Module shift_code_classify
//   code  : code word to classify
//   legal : code is reachable from the reference word (all-zeros or SEED)
//   idx   : smallest step count from the reference word, 0 when illegal
module shift_code_classify
    import shift_code_pkg::*;
#(
    parameter int             N    = 4,
    parameter int             RING = MODE_JOHNSON,
    parameter logic [N-1:0]   SEED = 4'b1001
) (
    input  logic [N-1:0]            code,
    output logic                    legal,
    output logic [$clog2(2*N)-1:0]  idx
);

    localparam int IW = $clog2(2*N);

    // Walk the counter from its reference word and take the first hit. In ring
    // mode only N steps are searched, so a SEED with a shorter rotational
    // period still reports its smallest rotation count.
    always_comb begin
        logic [N-1:0] walk;
        legal = 1'b0;
        idx   = '0;
        walk  = (RING == MODE_RING) ? SEED : '0;
        for (int i = 0; i < 2*N; i++) begin
            if (!legal && (walk == code) && ((RING != MODE_RING) || (i < N))) begin
                legal = 1'b1;
                idx   = IW'(i);
            end
            walk = (RING == MODE_RING) ? N'(ring_succ(MAX_N'(walk), N))
                                       : N'(johnson_succ(MAX_N'(walk), N));
        end
    end

endmodule

// File: rtl/shift_code_checker.sv
// rtl/shift_code_checker.sv - receive-side checker for ring/Johnson counter codes with lock FSM and error count
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   code_in     : sampled code word, taken when code_valid is high
//   idx, legal  : decode of the last valid sample
//   locked      : checker is in LOCKED
//   seq_err     : one-cycle pulse on a sequence break while locked
//   err_cnt     : saturating count of seq_err pulses, cleared only by rst
module shift_code_checker
    import shift_code_pkg::*;
#(
    parameter int             N        = 4,
    parameter int             RING     = MODE_JOHNSON,
    parameter logic [N-1:0]   SEED     = 4'b1001,
    parameter int             LOCK_CNT = 2,
    parameter int             ERR_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            code_in,
    input  logic                    code_valid,
    output logic [$clog2(2*N)-1:0]  idx,
    output logic                    legal,
    output logic                    locked,
    output logic                    seq_err,
    output logic [ERR_W-1:0]        err_cnt
);

    localparam int IW = $clog2(2*N);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]  LOCK_V      = GW'(LOCK_CNT);
    localparam chk_state_t     FIRST_STATE = (LOCK_CNT == 1) ? LOCKED : SYNC;

    chk_state_t     state;
    logic [N-1:0]   prev;
    logic [GW-1:0]  good;

    logic           c_legal;
    logic [IW-1:0]  c_idx;
    logic [N-1:0]   succ_prev;
    logic           match;

    shift_code_classify #(
        .N    (N),
        .RING (RING),
        .SEED (SEED)
    ) u_classify (
        .code  (code_in),
        .legal (c_legal),
        .idx   (c_idx)
    );

    assign succ_prev = (RING == MODE_RING) ? N'(ring_succ(MAX_N'(prev), N))
                                           : N'(johnson_succ(MAX_N'(prev), N));

    // A stalled (repeated) word never equals its own successor, so it falls
    // out as a mismatch here without a separate check.
    assign match = c_legal && (code_in == succ_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HUNT;
            prev    <= '0;
            good    <= '0;
            idx     <= '0;
            legal   <= 1'b0;
            seq_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            seq_err <= 1'b0;
            if (code_valid) begin
                idx   <= c_idx;
                legal <= c_legal;
                case (state)
                    HUNT: begin
                        if (c_legal) begin
                            prev  <= code_in;
                            good  <= GW'(1);
                            state <= FIRST_STATE;
                        end
                    end
                    SYNC: begin
                        if (!c_legal) begin
                            state <= HUNT;
                        end else if (match) begin
                            prev <= code_in;
                            good <= good + GW'(1);
                            if ((good + GW'(1)) == LOCK_V) begin
                                state <= LOCKED;
                            end
                        end else begin
                            prev <= code_in;
                            good <= GW'(1);
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            prev <= code_in;
                        end else begin
                            seq_err <= 1'b1;
                            if (err_cnt != {ERR_W{1'b1}}) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                            // A legal break word already counts as the first
                            // in-sequence sample of the re-sync attempt.
                            if (c_legal) begin
                                prev  <= code_in;
                                good  <= GW'(1);
                                state <= SYNC;
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule
